// File: rtl/dft_pkg.sv
// Shared constants, state encoding and lane helpers for the 16-lane streaming DFT scheduler.
package dft_pkg;

   localparam int unsigned LANES    = 16;
   localparam int unsigned WORD_W   = 32;
   localparam int unsigned CORE_LAT = 54;
   localparam int unsigned VEC_W    = LANES * WORD_W;

   typedef enum logic {
      IN_IDLE,
      IN_STREAM
   } in_state_e;

   function automatic logic [WORD_W-1:0] lane_get(input logic [VEC_W-1:0] vec,
                                                  input int unsigned lane);
      return vec[lane*WORD_W +: WORD_W];
   endfunction

   function automatic logic [VEC_W-1:0] lane_set(input logic [VEC_W-1:0] vec,
                                                 input int unsigned lane,
                                                 input logic [WORD_W-1:0] word);
      logic [VEC_W-1:0] res;
      res = vec;
      res[lane*WORD_W +: WORD_W] = word;
      return res;
   endfunction

endpackage

// File: rtl/dft_out_framer.sv
// Re-frames core output into valid/sof/eof-marked vectors and owns the sticky sync error.
module dft_out_framer
   import dft_pkg::*;
#(
   parameter int unsigned FRAME_CYCLES = 1,
   parameter int unsigned VW           = VEC_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          core_next_out,
   input  logic [VW-1:0] core_y,
   input  logic          inflight_zero,
   output logic          m_valid,
   output logic          m_sof,
   output logic          m_eof,
   output logic [VW-1:0] m_data,
   output logic          frame_done,
   output logic          sync_err
);

   localparam int unsigned OC_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

   logic            active_q, active_d;
   logic [OC_W-1:0] ocnt_q, ocnt_d;
   logic            m_valid_q, m_valid_d;
   logic            m_sof_q, m_sof_d;
   logic            m_eof_q, m_eof_d;
   logic [VW-1:0]   m_data_q, m_data_d;
   logic            sync_err_q, sync_err_d;
   logic            last;

   always_comb begin
      active_d   = active_q;
      ocnt_d     = ocnt_q;
      m_valid_d  = 1'b0;
      m_sof_d    = 1'b0;
      m_eof_d    = 1'b0;
      m_data_d   = '0;
      sync_err_d = sync_err_q;
      last       = (ocnt_q == OC_W'(FRAME_CYCLES - 1));

      if (active_q) begin
         m_valid_d = 1'b1;
         m_sof_d   = (ocnt_q == '0);
         m_eof_d   = last;
         m_data_d  = core_y;
         if (last) begin
            active_d = 1'b0;
            ocnt_d   = '0;
         end else begin
            ocnt_d = ocnt_q + 1'b1;
         end
      end

      // A fresh core frame pre-empts an unfinished one; the current vector is still emitted.
      if (core_next_out) begin
         if (inflight_zero) begin
            sync_err_d = 1'b1;
         end else begin
            if (active_q && !last) sync_err_d = 1'b1;
            active_d = 1'b1;
            ocnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_q   <= 1'b0;
         ocnt_q     <= '0;
         m_valid_q  <= 1'b0;
         m_sof_q    <= 1'b0;
         m_eof_q    <= 1'b0;
         m_data_q   <= '0;
         sync_err_q <= 1'b0;
      end else begin
         active_q   <= active_d;
         ocnt_q     <= ocnt_d;
         m_valid_q  <= m_valid_d;
         m_sof_q    <= m_sof_d;
         m_eof_q    <= m_eof_d;
         m_data_q   <= m_data_d;
         sync_err_q <= sync_err_d;
      end
   end

   assign m_valid    = m_valid_q;
   assign m_sof      = m_sof_q;
   assign m_eof      = m_eof_q;
   assign m_data     = m_data_q;
   assign frame_done = m_eof_d;
   assign sync_err   = sync_err_q;

endmodule

// File: rtl/dft_stream_sched.sv
// Frame scheduler for the streaming DFT core: input framing, core drive, in-flight tracking.
module dft_stream_sched #(
   parameter int unsigned FRAME_CYCLES = 1,
   parameter int unsigned LANES        = dft_pkg::LANES,
   parameter int unsigned WORD_W       = dft_pkg::WORD_W,
   parameter int unsigned CORE_LAT     = dft_pkg::CORE_LAT,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [LANES*WORD_W-1:0]   s_data,
   output logic                      core_next,
   output logic [LANES*WORD_W-1:0]   core_x,
   input  logic                      core_next_out,
   input  logic [LANES*WORD_W-1:0]   core_y,
   output logic                      m_valid,
   output logic                      m_sof,
   output logic                      m_eof,
   output logic [LANES*WORD_W-1:0]   m_data,
   output logic                      busy,
   output logic [CNT_W-1:0]          frames_done,
   output logic                      underrun_err,
   output logic                      sync_err
);

   import dft_pkg::*;

   localparam int unsigned VW           = LANES * WORD_W;
   localparam int unsigned MAX_INFLIGHT = (CORE_LAT + 2 + FRAME_CYCLES - 1) / FRAME_CYCLES + 1;
   localparam int unsigned IF_W         = $clog2(MAX_INFLIGHT + 1);
   localparam int unsigned IC_W         = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

   in_state_e        state_q, state_d;
   logic [IC_W-1:0]  icnt_q, icnt_d;
   logic [IF_W-1:0]  inflight_q, inflight_d;
   logic             run_q, run_d;
   logic             core_next_q, core_next_d;
   logic [VW-1:0]    x1_q, x1_d;
   logic [VW-1:0]    core_x_q, core_x_d;
   logic             underrun_q, underrun_d;
   logic [CNT_W-1:0] frames_done_q, frames_done_d;
   logic             start;
   logic             frame_done;

   // run_q keeps s_ready low until the first clock after reset release.
   always_comb begin
      state_d     = state_q;
      icnt_d      = icnt_q;
      run_d       = 1'b1;
      s_ready     = 1'b0;
      start       = 1'b0;
      x1_d        = '0;
      underrun_d  = underrun_q;

      case (state_q)
         IN_IDLE: begin
            s_ready = run_q && enable;
            if (s_ready && s_valid) begin
               start = 1'b1;
               x1_d  = s_data;
               if (FRAME_CYCLES > 1) begin
                  state_d = IN_STREAM;
                  icnt_d  = IC_W'(1);
               end
            end
         end
         IN_STREAM: begin
            s_ready = 1'b1;
            x1_d    = s_valid ? s_data : '0;
            if (!s_valid) underrun_d = 1'b1;
            if (icnt_q == IC_W'(FRAME_CYCLES - 1)) begin
               state_d = IN_IDLE;
               icnt_d  = '0;
            end else begin
               icnt_d = icnt_q + 1'b1;
            end
         end
         default: state_d = IN_IDLE;
      endcase

      core_next_d = start;
      core_x_d    = x1_q;
   end

   always_comb begin
      inflight_d    = inflight_q;
      frames_done_d = frames_done_q;
      if (start && !frame_done) begin
         if (inflight_q != IF_W'(MAX_INFLIGHT)) inflight_d = inflight_q + 1'b1;
      end else if (!start && frame_done && (inflight_q != '0)) begin
         inflight_d = inflight_q - 1'b1;
      end
      if (frame_done) frames_done_d = frames_done_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IN_IDLE;
         icnt_q        <= '0;
         inflight_q    <= '0;
         run_q         <= 1'b0;
         core_next_q   <= 1'b0;
         x1_q          <= '0;
         core_x_q      <= '0;
         underrun_q    <= 1'b0;
         frames_done_q <= '0;
      end else begin
         state_q       <= state_d;
         icnt_q        <= icnt_d;
         inflight_q    <= inflight_d;
         run_q         <= run_d;
         core_next_q   <= core_next_d;
         x1_q          <= x1_d;
         core_x_q      <= core_x_d;
         underrun_q    <= underrun_d;
         frames_done_q <= frames_done_d;
      end
   end

   dft_out_framer #(
      .FRAME_CYCLES (FRAME_CYCLES),
      .VW           (VW)
   ) u_framer (
      .clk           (clk),
      .reset         (reset),
      .core_next_out (core_next_out),
      .core_y        (core_y),
      .inflight_zero (inflight_q == '0),
      .m_valid       (m_valid),
      .m_sof         (m_sof),
      .m_eof         (m_eof),
      .m_data        (m_data),
      .frame_done    (frame_done),
      .sync_err      (sync_err)
   );

   assign core_next    = core_next_q;
   assign core_x       = core_x_q;
   assign busy         = (state_q != IN_IDLE) || (inflight_q != '0);
   assign frames_done  = frames_done_q;
   assign underrun_err = underrun_q;

endmodule

// File: doc/dft_stream_sched.md
Name: dft_stream_sched

Overview:
Frame scheduler for the 16-lane streaming DFT core (latency 54 cycles, gap 1; 16 × 32-bit complex words per cycle).
- Accepts input vectors over a valid/ready interface and groups them into frames of FRAME_CYCLES vectors.
- Issues the core's next pulse one cycle before the frame's first vector and keeps each frame contiguous.
- Re-frames the core output with valid, start-of-frame (sof) and end-of-frame (eof) markers.
- Tracks frames in flight and reports sticky errors.

Parameters:
- FRAME_CYCLES, 1: input vectors per frame; 1 matches the 16-point core with gap 1.
- LANES, 16: complex words per vector.
- WORD_W, 32: bits per complex word.
- CORE_LAT, 54: cycles from core_next to core_next_out.
- CNT_W, 16: width of frames_done.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  allows new frames to start; in-flight frames always complete.
- s_valid  in  1  input vector valid.
- s_ready  out  1  input vector accepted.
- s_data  in  512  input vector; lane i occupies bits [32i+31:32i].
- core_next  out  1  to core next.
- core_x  out  512  to core X0..X15, same lane map.
- core_next_out  in  1  from core next_out.
- core_y  in  512  from core Y0..Y15.
- m_valid  out  1  output vector valid; no backpressure.
- m_sof  out  1  first vector of an output frame.
- m_eof  out  1  last vector of an output frame.
- m_data  out  512  output vector.
- busy  out  1  frame being fed or frames in flight.
- frames_done  out  CNT_W  completed output frames; wraps.
- underrun_err  out  1  sticky: s_valid low mid-frame.
- sync_err  out  1  sticky: unexpected core_next_out.

Behaviour:
- Reset (reset=0, asynchronous):
  - Every output is 0, including core_x and m_data.
  - All counters are cleared and the FSM goes to IDLE.
  - Integration drives the core's active-high reset from ~reset.
- Input FSM, vector counter icnt in 0..FRAME_CYCLES-1:
  - IDLE: s_ready=enable. A frame starts on s_valid&&enable: icnt←1 (or stays IDLE when FRAME_CYCLES=1), inflight++.
  - STREAM: s_ready=1 unconditionally and icnt advances every cycle. If s_valid=0, the vector is replaced by zeros and underrun_err←1.
  - On the last vector, return to IDLE. A new frame may start the very next cycle, so frames run back-to-back.
- Core drive, with T = the cycle a vector is accepted:
  - core_next(T+1)=1 for the first vector of a frame.
  - core_x(T+2)=s_data(T). Both are registered.
  - core_next may therefore coincide with the previous frame's last data cycle, which is legal.
- Output framer:
  - core_next_out at cycle t means core_y vectors at t+1..t+FRAME_CYCLES.
  - m_data/m_valid are registered: m_valid at t+2..t+FRAME_CYCLES+1.
  - m_sof is asserted on the first of these vectors and m_eof on the last.
  - A frame is complete on m_eof: inflight--, frames_done++.
- End-to-end latency: s_data accepted at T → m_data at T+CORE_LAT+3 = T+57.
- Boundary conditions:
  - core_next_out while the output counter is not at its last vector: sync_err←1 and the counter restarts (the new frame wins).
  - core_next_out with inflight==0: ignored, sync_err←1.
  - Start and completion in the same cycle: inflight is unchanged.
  - inflight saturates at ceil((CORE_LAT+2)/FRAME_CYCLES)+1.
- busy = (state!=IDLE) || (inflight!=0).
- enable falling mid-frame: the current frame completes, then IDLE holds s_ready=0.

Decomposition:
- Shared package dft_pkg: LANES, WORD_W, CORE_LAT=54, VEC_W=LANES*WORD_W, and lane-slice helper functions.
- One sub-module, dft_out_framer: core_next_out/core_y → m_valid/m_sof/m_eof/m_data, plus the sync_err source.

Test Plan:
- FRAME_CYCLES=1, one vector with lane i=i, accepted at T=10 → core_next=1 at 11; m_valid=m_sof=m_eof=1 at 67 with the core result; frames_done=1.
- s_valid held for 20 cycles → core_next high for 20 consecutive cycles; 20 contiguous m_valid; frames_done=20; busy drops 57 cycles after the last accept.
- FRAME_CYCLES=4, s_valid low on vector 2 → core_x is all zeros at that slot; underrun_err=1; frame still completes with m_sof/m_eof 4 vectors apart.
- enable dropped mid-frame (FRAME_CYCLES=4) → remaining vectors accepted; then s_ready=0; only that frame appears on the output.
- core_next_out pulsed with nothing in flight → sync_err=1; m_valid stays 0.
- reset asserted mid-stream → all outputs are 0 in the same cycle; after release the next frame behaves as in the first scenario.
